// File: rtl/pipe_pkg.sv
// Shared opcode decode, PC-select encodings and FSM state type for the
// 4-stage pipeline hazard/redirect controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_TGT  = 2'd1;
    localparam logic [1:0] PC_SEL_RET  = 2'd2;
    localparam logic [1:0] PC_SEL_HOLD = 2'd3;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_CLR = 8'h01;
    localparam logic [7:0] OP_JUD = 8'h03;
    localparam logic [7:0] OP_JUA = 8'h04;
    localparam logic [7:0] OP_CUD = 8'h05;
    localparam logic [7:0] OP_CUA = 8'h06;
    localparam logic [7:0] OP_RTU = 8'h07;
    localparam logic [7:0] OP_RSP = 8'h18;
    localparam logic [7:0] OP_RLA = 8'h60;
    localparam logic [7:0] OP_RRA = 8'h70;

    // Conditional classes are matched on the upper five bits; [2:0] is the flag select.
    localparam logic [4:0] OP_JCD_P = 5'b00001;
    localparam logic [4:0] OP_JCA_P = 5'b00101;
    localparam logic [4:0] OP_CCD_P = 5'b00110;
    localparam logic [4:0] OP_CCA_P = 5'b00111;
    localparam logic [4:0] OP_RTC_P = 5'b01001;

    function automatic logic is_uncond(input logic [7:0] op);
        return (op == OP_JUD) || (op == OP_JUA) || (op == OP_CUD) ||
               (op == OP_CUA) || (op == OP_RTU);
    endfunction

    function automatic logic is_cond(input logic [7:0] op);
        return (op[7:3] == OP_JCD_P) || (op[7:3] == OP_JCA_P) ||
               (op[7:3] == OP_CCD_P) || (op[7:3] == OP_CCA_P) ||
               (op[7:3] == OP_RTC_P);
    endfunction

    function automatic logic is_return(input logic [7:0] op);
        return (op == OP_RTU) || (op[7:3] == OP_RTC_P);
    endfunction

    function automatic logic writes_rn(input logic [7:0] op);
        return (op == OP_CLR) ||
               ((op[7:3] == 5'b00010) && (op != 8'h10)) ||
               (op[7:3] == 5'b00100) ||
               (op[7:3] == 5'b01000) ||
               (op[7:4] == 4'b0101) ||
               ((op[7:3] == 5'b01110) && (op != OP_RRA)) ||
               (op[7:3] == 5'b01111) ||
               (op[7] && op[3] && (op[7:3] != 5'b11111));
    endfunction

    function automatic logic writes_r0(input logic [7:0] op);
        return (op == OP_CLR) || (op == OP_RSP) || (op == OP_RLA) ||
               (op == OP_RRA) || (op[7] && !op[3]);
    endfunction

    function automatic logic reads_rn(input logic [7:0] op);
        return ((op[7:3] == 5'b00011) && (op != OP_RSP)) ||
               (op[7:3] == 5'b00100) ||
               (op[7:3] == 5'b01000) ||
               (op[7:3] == 5'b01010) ||
               ((op[7:3] == 5'b01100) && (op != OP_RLA)) ||
               (op[7:3] == 5'b01101) ||
               (op[7] && !op[3] && (op[7:3] != 5'b11110)) ||
               (op[7] && op[3] && (op[7:3] != 5'b11111));
    endfunction

    function automatic logic reads_r0(input logic [7:0] op);
        return (op[7:3] == 5'b01100) || (op == OP_RRA) ||
               (op[7] && !op[3]) || (op[7:3] == 5'b11111);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Opcode/flag inputs and control outputs between the pipeline datapath
// (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       opcode_s2;
    logic [7:0]       opcode_s3;
    logic [7:0]       opcode_s4;
    logic             FL;
    logic             stall_s12;
    logic             bubble_s3;
    logic             flush;
    logic [1:0]       pc_sel;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output opcode_s2, opcode_s3, opcode_s4, FL,
        input  stall_s12, bubble_s3, flush, pc_sel, busy, stall_cnt
    );

    modport slave (
        input  opcode_s2, opcode_s3, opcode_s4, FL,
        output stall_s12, bubble_s3, flush, pc_sel, busy, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational read-after-write check of the decode-stage opcode against
// the two older in-flight opcodes (S3, S4).
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [7:0] opcode_s2,
    input  logic [7:0] opcode_s3,
    input  logic [7:0] opcode_s4,
    output logic       raw
);
    logic [7:0] older_op [2];
    logic [1:0] hit;

    assign older_op[0] = opcode_s3;
    assign older_op[1] = opcode_s4;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_older
            assign hit[gi] =
                (reads_rn(opcode_s2) && writes_rn(older_op[gi]) &&
                 (opcode_s2[2:0] == older_op[gi][2:0])) ||
                (reads_r0(opcode_s2) && writes_r0(older_op[gi]));
        end
    endgenerate

    assign raw = |hit;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: S4 redirect/flush, S2 RAW stall, PC select and a
// saturating stall-cycle counter.
module pipeline_hazard_controller
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_controller_if.slave   bus
);
    state_t           state_reg, state_next;
    logic [2:0]       flush_ctr_reg, flush_ctr_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic       raw;
    logic       taken;
    logic       stall_c, bubble_c, flush_c;
    logic [1:0] pc_sel_c;

    hazard_detect u_hazard_detect (
        .opcode_s2 (bus.opcode_s2),
        .opcode_s3 (bus.opcode_s3),
        .opcode_s4 (bus.opcode_s4),
        .raw       (raw)
    );

    // FL is only consulted for conditional classes, so X on it elsewhere is harmless.
    assign taken = is_uncond(bus.opcode_s4) || (is_cond(bus.opcode_s4) && bus.FL);

    always_comb begin
        state_next     = state_reg;
        flush_ctr_next = flush_ctr_reg;
        stall_c        = 1'b0;
        bubble_c       = 1'b0;
        flush_c        = 1'b0;
        pc_sel_c       = PC_SEL_INC;
        case (state_reg)
            ST_RUN, ST_STALL: begin
                if (taken) begin
                    flush_c        = 1'b1;
                    pc_sel_c       = is_return(bus.opcode_s4) ? PC_SEL_RET : PC_SEL_TGT;
                    flush_ctr_next = 3'(FLUSH_CYCLES - 1);
                    state_next     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (raw) begin
                    stall_c    = 1'b1;
                    bubble_c   = 1'b1;
                    pc_sel_c   = PC_SEL_HOLD;
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // S4 only carries bubbles here, so its opcode and RAW are ignored.
                flush_c        = 1'b1;
                flush_ctr_next = flush_ctr_reg - 3'd1;
                if (flush_ctr_reg <= 3'd1) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next     = ST_RUN;
                flush_ctr_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            flush_ctr_reg <= 3'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_ctr_reg <= flush_ctr_next;
            if (stall_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is asserted, independent of the opcode inputs.
    assign bus.stall_s12 = rst_n & stall_c;
    assign bus.bubble_s3 = rst_n & bubble_c;
    assign bus.flush     = rst_n & flush_c;
    assign bus.pc_sel    = rst_n ? pc_sel_c : PC_SEL_INC;
    assign bus.busy      = rst_n & (state_reg != ST_RUN);
    assign bus.stall_cnt = stall_cnt_reg;
endmodule
